// File: rtl/arcade_input_ctrl.sv
// Arcade control conditioner: merges joystick words with PS/2 key latches, adds autofire and coin shaping.
// Latency: joy_in to outputs 1 cycle, key_strobe to outputs 2 cycles; coin rises 3 cycles after a request edge.
// No backpressure: coin requests queue up to 3 deep (further edges are dropped); everything else is level-based.
module arcade_input_ctrl #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 8,
  parameter int COIN_PULSE   = 16,
  parameter int COIN_GAP     = 16,
  parameter int AUTOFIRE_DIV = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_strobe,
  input  logic                            key_pressed,
  input  logic [7:0]                      key_code,
  input  logic [PLAYERS*(BUTTONS+6)-1:0]  joy_in,
  input  logic [BUTTONS-1:0]              autofire_mask,
  output logic [PLAYERS*(BUTTONS+4)-1:0]  players,
  output logic [PLAYERS-1:0]              starts,
  output logic [PLAYERS-1:0]              coins,
  output logic                            tilt
);

  localparam int JW   = BUTTONS + 6;                       // joystick slice width
  localparam int OW   = BUTTONS + 4;                       // player output slice width
  localparam int KP   = (PLAYERS < 2) ? PLAYERS : 2;       // channels that have keyboard mappings
  localparam int TMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(AUTOFIRE_DIV);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_st_t;

  // Key decode results
  logic pl_hit, st_hit, cn_hit, esc_hit, tilt_hit;
  int   pl_idx, pl_bit, st_idx, cn_idx;

  // Key latches
  logic [OW-1:0]      kpl_q [KP];
  logic [OW-1:0]      kpl_d [KP];
  logic [PLAYERS-1:0] kst_q, kst_d, kcn_q, kcn_d;
  logic               kesc_q, kesc_d, ktilt_q, ktilt_d;

  // Merged controls
  logic [OW-1:0]      held [PLAYERS];
  logic [PLAYERS-1:0] start_req, coin_req;

  // Autofire divider
  logic               any_masked;
  logic [DW-1:0]      div_q, div_d;
  logic               phase_q, phase_d;

  // Output registers
  logic [PLAYERS*OW-1:0] players_q, players_d;
  logic [PLAYERS-1:0]    starts_q, starts_d;
  logic                  tilt_q, tilt_d;

  // Map a PS/2 code onto the control it drives; bits are [3:0] UDLR, [4+] fires A..H
  always_comb begin
    pl_hit = 1'b0; pl_idx = 0; pl_bit = 0;
    st_hit = 1'b0; st_idx = 0;
    cn_hit = 1'b0; cn_idx = 0;
    esc_hit = 1'b0; tilt_hit = 1'b0;
    case (key_code)
      8'h75: begin pl_hit = 1'b1; pl_bit = 3; end
      8'h72: begin pl_hit = 1'b1; pl_bit = 2; end
      8'h6B: begin pl_hit = 1'b1; pl_bit = 1; end
      8'h74: begin pl_hit = 1'b1; pl_bit = 0; end
      8'h29: begin pl_hit = 1'b1; pl_bit = 4; end
      8'h11: begin pl_hit = 1'b1; pl_bit = 5; end
      8'h14: begin pl_hit = 1'b1; pl_bit = 6; end
      8'h12: begin pl_hit = 1'b1; pl_bit = 7; end
      8'h1A: begin pl_hit = 1'b1; pl_bit = 8; end
      8'h22: begin pl_hit = 1'b1; pl_bit = 9; end
      8'h21: begin pl_hit = 1'b1; pl_bit = 10; end
      8'h2A: begin pl_hit = 1'b1; pl_bit = 11; end
      8'h2D: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 3; end
      8'h2B: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 2; end
      8'h23: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 1; end
      8'h34: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 0; end
      8'h1C: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 4; end
      8'h1B: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 5; end
      8'h15: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 6; end
      8'h1D: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 7; end
      8'h43: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 8; end
      8'h42: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 9; end
      8'h3B: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 10; end
      8'h4B: begin pl_hit = 1'b1; pl_idx = 1; pl_bit = 11; end
      8'h05, 8'h16: begin st_hit = 1'b1; st_idx = 0; end
      8'h06, 8'h1E: begin st_hit = 1'b1; st_idx = 1; end
      8'h04, 8'h26: begin st_hit = 1'b1; st_idx = 2; end
      8'h0C, 8'h25: begin st_hit = 1'b1; st_idx = 3; end
      8'h2E: begin cn_hit = 1'b1; cn_idx = 0; end
      8'h36: begin cn_hit = 1'b1; cn_idx = 1; end
      8'h3D: begin cn_hit = 1'b1; cn_idx = 2; end
      8'h3E: begin cn_hit = 1'b1; cn_idx = 3; end
      8'h76: esc_hit = 1'b1;
      8'h66: tilt_hit = 1'b1;
      default: ;
    endcase
  end

  // Next key latch state; codes for absent buttons or channels match no latch bit
  always_comb begin
    kpl_d   = kpl_q;
    kst_d   = kst_q;
    kcn_d   = kcn_q;
    kesc_d  = kesc_q;
    ktilt_d = ktilt_q;
    if (key_strobe) begin
      for (int p = 0; p < KP; p++) begin
        for (int b = 0; b < OW; b++) begin
          if (pl_hit && pl_idx == p && pl_bit == b) kpl_d[p][b] = key_pressed;
        end
      end
      for (int p = 0; p < PLAYERS; p++) begin
        if (st_hit && st_idx == p) kst_d[p] = key_pressed;
        if (cn_hit && cn_idx == p) kcn_d[p] = key_pressed;
      end
      if (esc_hit)  kesc_d  = key_pressed;
      if (tilt_hit) ktilt_d = key_pressed;
    end
  end

  // Key latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < KP; p++) kpl_q[p] <= '0;
      kst_q   <= '0;
      kcn_q   <= '0;
      kesc_q  <= 1'b0;
      ktilt_q <= 1'b0;
    end else begin
      for (int p = 0; p < KP; p++) kpl_q[p] <= kpl_d[p];
      kst_q   <= kst_d;
      kcn_q   <= kcn_d;
      kesc_q  <= kesc_d;
      ktilt_q <= ktilt_d;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_merge
    if (p < KP) begin : g_key
      assign held[p] = joy_in[p*JW +: OW] | kpl_q[p];
    end else begin : g_joy
      assign held[p] = joy_in[p*JW +: OW];
    end
    assign start_req[p] = joy_in[p*JW + BUTTONS + 4] | kst_q[p];
    assign coin_req[p]  = joy_in[p*JW + BUTTONS + 5] | kcn_q[p] | kesc_q;
  end

  // Autofire divider: parked at phase=1 while nothing masked is held so a fresh press fires at once
  always_comb begin
    any_masked = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (|(held[p][OW-1:4] & autofire_mask)) any_masked = 1'b1;
    end
    div_d   = div_q;
    phase_d = phase_q;
    if (!any_masked) begin
      div_d   = '0;
      phase_d = 1'b1;
    end else if (div_q == DW'(AUTOFIRE_DIV - 1)) begin
      div_d   = '0;
      phase_d = ~phase_q;
    end else begin
      div_d   = div_q + DW'(1);
    end
  end

  // Output words: directions pass through, masked fires are gated by the autofire phase
  always_comb begin
    players_d = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      players_d[p*OW +: OW] = {held[p][OW-1:4] & ({BUTTONS{phase_q}} | ~autofire_mask),
                               held[p][3:0]};
    end
    starts_d = start_req;
    tilt_d   = ktilt_q;
  end

  // Divider and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      phase_q   <= 1'b1;
      players_q <= '0;
      starts_q  <= '0;
      tilt_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      phase_q   <= phase_d;
      players_q <= players_d;
      starts_q  <= starts_d;
      tilt_q    <= tilt_d;
    end
  end

  assign players = players_q;
  assign starts  = starts_q;
  assign tilt    = tilt_q;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
    coin_st_t      st_q;
    logic [TW-1:0] tmr_q;
    logic [1:0]    pend_q;
    logic          req_q;
    logic          coin_q;
    logic          rise;
    logic          take;

    assign rise     = coin_req[p] & ~req_q;
    assign take     = (st_q == C_IDLE) && (pend_q != 2'd0);
    assign coins[p] = coin_q;

    // Coin shaper: queue request edges, then play fixed pulse + guaranteed low gap per coin
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q   <= C_IDLE;
        tmr_q  <= '0;
        pend_q <= 2'd0;
        req_q  <= 1'b0;
        coin_q <= 1'b0;
      end else begin
        req_q  <= coin_req[p];
        coin_q <= (st_q == C_PULSE);
        case ({rise, take})
          2'b10:   if (pend_q != 2'd3) pend_q <= pend_q + 2'd1;
          2'b01:   pend_q <= pend_q - 2'd1;
          default: ;
        endcase
        case (st_q)
          C_IDLE: begin
            if (take) begin
              st_q  <= C_PULSE;
              tmr_q <= TW'(COIN_PULSE - 1);
            end
          end
          C_PULSE: begin
            if (tmr_q == '0) begin
              st_q  <= C_GAP;
              tmr_q <= TW'(COIN_GAP - 1);
            end else begin
              tmr_q <= tmr_q - TW'(1);
            end
          end
          C_GAP: begin
            if (tmr_q == '0) st_q <= C_IDLE;
            else             tmr_q <= tmr_q - TW'(1);
          end
          default: st_q <= C_IDLE;
        endcase
      end
    end
  end

endmodule
